inst_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage with a prefetch queue, for the KGP-RISC pipeline.
//  - Owns the PC and issues one word request per cycle to a synchronous instruction memory
//    (read latency 1).
//  - Buffers returned words with their PC and NPC in a FIFO, then hands them to decode over
//    a valid/ready handshake.
//  - Accepts a redirect (branch/jump target) from EX, which flushes all fetched and in-flight

---
 rtl/inst_fetch_unit.sv | 138 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word read per cycle to a
// latency-1 instruction memory and buffers returned words in a prefetch queue.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_BOOT | single idle cycle after reset release, no request issued
//   ST_RUN  | issue one request per cycle while queue has room
//   ST_HALT | no new requests; in-flight response and decode drain continue
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       PC_STEP    = 4,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               halt_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_o,
  output logic [ADDR_W-1:0]  out_npc_o,
  output logic               busy_o
);

  localparam int unsigned       PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned       CNT_W = PTR_W + 1;
  localparam int unsigned       OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
  localparam logic [OCC_W-1:0]  DEPTH = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [INSTR_W-1:0] instr_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [FIFO_DEPTH];
  logic [ADDR_W-1:0]  npc_mem_q   [FIFO_DEPTH];

  logic               push, pop, issue, not_empty;
  logic [OCC_W-1:0]   occupancy;

  assign not_empty = (count_q != '0);
  // An outstanding request already owns a queue slot, so it counts as occupied.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = not_empty & out_ready_i;
    issue      = (state_q == ST_RUN) & ~halt_i & ~redirect_i & (occupancy < DEPTH);

    case (state_q)
      ST_BOOT: state_d = halt_i ? ST_HALT : ST_RUN;
      ST_RUN:  state_d = halt_i ? ST_HALT : ST_RUN;
      ST_HALT: state_d = halt_i ? ST_HALT : ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (redirect_i) begin
      // Flush everything; the response landing this cycle is simply not pushed.
      pc_d     = redirect_pc_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      push = inflight_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (issue) begin
        pc_d       = pc_q + STEP;
        req_pc_d   = pc_q;
        inflight_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      npc_mem_q[wr_ptr_q]   <= req_pc_q + STEP;
    end
  end

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign out_valid_o = not_empty;
  // Head fields read as zero when the queue is empty.
  assign out_instr_o = not_empty ? instr_mem_q[rd_ptr_q] : '0;
  assign out_pc_o    = not_empty ? pc_mem_q[rd_ptr_q]    : '0;
  assign out_npc_o   = not_empty ? npc_mem_q[rd_ptr_q]   : '0;
  assign busy_o      = inflight_q | not_empty;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: cycle-level queue model of the fetch stage, directed
// scenarios with literal pins, then randomized redirect/halt/ready traffic.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, redirect, halt, out_ready, out_valid, busy;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc, out_npc;

  logic        w_req, w_valid, w_busy;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_npc;

  inst_fetch_unit u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .halt_i(halt),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
    .out_pc_o(out_pc), .out_npc_o(out_npc), .busy_o(busy)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_rdata_i(w_rdata),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .halt_i(1'b0),
    .out_valid_o(w_valid), .out_ready_i(1'b1), .out_instr_o(w_instr),
    .out_pc_o(w_pc), .out_npc_o(w_npc), .busy_o(w_busy)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  always @(posedge clk) if (imem_req) imem_rdata <= memfn(imem_addr);
  always @(posedge clk) if (w_req)    w_rdata    <= memfn(w_addr);

  int checks = 0;
  int errors = 0;

  // Model: PC register, ordered list of queued PCs (data is a function of PC),
  // one optional outstanding request, and mode 0=boot 1=run 2=halt.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  int          m_mode;

  logic        s_req, s_valid, s_busy;
  logic [31:0] s_addr, s_pc, s_npc, s_instr;
  bit          wrap_on = 1'b0;
  logic [31:0] wq[$];
  logic [31:0] wnq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_req();
    return (m_mode == 1) && !halt && !redirect && ((m_q.size() + int'(m_infl)) < 4);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_q.delete();
    m_infl = 1'b0;
    m_infl_pc = 32'h0;
    m_mode = 0;
  endtask

  task automatic compare();
    bit          ev;
    logic [31:0] hp;
    ev = (m_q.size() != 0);
    hp = ev ? m_q[0] : 32'h0;
    chk("imem_req",  imem_req,  exp_req());
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", out_valid, ev);
    chk("out_pc",    out_pc,    hp);
    chk("out_npc",   out_npc,   ev ? hp + 32'd4 : 32'h0);
    chk("out_instr", out_instr, ev ? memfn(hp) : 32'h0);
    chk("busy",      busy,      m_infl || ev);
  endtask

  task automatic model_update();
    bit pop, req;
    pop = (m_q.size() != 0) && out_ready;
    req = exp_req();
    if (redirect) begin
      m_q.delete();
      m_pc   = redirect_pc;
      m_infl = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      if (req) begin
        m_infl    = 1'b1;
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    m_mode = halt ? 2 : 1;
  endtask

  task automatic cycle(input bit rd, input logic [31:0] rpc, input bit h, input bit rdy);
    redirect = rd; redirect_pc = rpc; halt = h; out_ready = rdy;
    @(negedge clk);
    compare();
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_busy = busy;
    s_pc = out_pc; s_npc = out_npc; s_instr = out_instr;
    if (wrap_on && w_valid) begin
      wq.push_back(w_pc);
      wnq.push_back(w_npc);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   imem_req,  32'h0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_valid"}, out_valid, 32'h0);
    chk({tag, "_instr"}, out_instr, 32'h0);
    chk({tag, "_pc"},    out_pc,    32'h0);
    chk({tag, "_npc"},   out_npc,   32'h0);
    chk({tag, "_busy"},  busy,      32'h0);
  endtask

  initial begin : main
    bit found;
    bit h_r;
    bit rd_r;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0; out_ready = 1'b0;
    imem_rdata = 32'h0; w_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    wrap_on = 1'b1;

    // Boot and sequential streaming
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (c == 2) chk("boot_c2_valid", s_valid, 32'h0);
      if (c == 3) begin
        chk("boot_c3_valid", s_valid, 32'h1);
        chk("boot_c3_pc",    s_pc,    32'h0);
        chk("boot_c3_instr", s_instr, 32'h1000);
        chk("boot_c3_npc",   s_npc,   32'h4);
      end
      if (c == 4) chk("boot_c4_pc", s_pc, 32'h4);
    end
    wrap_on = 1'b0;
    chk("wrap_count", wq.size() >= 3, 32'h1);
    if (wq.size() >= 3) begin
      chk("wrap_pc0",  wq[0],  32'hFFFF_FFF8);
      chk("wrap_pc1",  wq[1],  32'hFFFF_FFFC);
      chk("wrap_pc2",  wq[2],  32'h0000_0000);
      chk("wrap_npc1", wnq[1], 32'h0000_0000);
    end

    // Decode stall fills the queue
    repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_req",   s_req,   32'h0);
    chk("stall_busy",  s_busy,  32'h1);
    chk("stall_valid", s_valid, 32'h1);
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Redirect with queued and in-flight work
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h200, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("redir_req",   s_req,   32'h1);
    chk("redir_addr",  s_addr,  32'h200);
    chk("redir_valid", s_valid, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (s_valid) begin
        chk("redir_first_pc", s_pc, 32'h200);
        found = 1'b1;
        break;
      end
    end
    chk("redir_seen", found, 32'h1);

    // Halt mid-stream
    repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("halt_req", s_req, 32'h0);
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset with a request in flight
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (s_valid) begin
        chk("midrst_first_pc", s_pc, 32'h0);
        found = 1'b1;
        break;
      end
    end
    chk("midrst_seen", found, 32'h1);

    // Randomized traffic
    h_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) h_r = ~h_r;
      rd_r = ($urandom_range(0, 99) < 4);
      cycle(rd_r, $urandom, h_r, ($urandom_range(0, 99) < 70));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
